sr_bank_arbiter: RTL and testbench

//   Shares one bank of SR flag cells between NREQ requesters.

---
 rtl/sr_bank_arbiter.sv | 125 ++++++++++++
 tb/tb_sr_bank_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter in front of a shared bank of SR flag cells.
// Each operation takes three cycles: grant in IDLE, write in APPLY, acknowledge in ACK.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       s,
  input  logic [NREQ-1:0]       r,
  input  logic [NREQ*IDX_W-1:0] idx,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic                  busy,
  output logic [NBITS-1:0]      q,
  output logic [NBITS-1:0]      qbar
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_l;
  logic             s_l;
  logic             r_l;
  logic [IDX_W-1:0] idx_l;

  logic             any_req;
  logic [PTR_W-1:0] gnt;
  int               cand;
  logic             sel_s;
  logic             sel_r;
  logic [IDX_W-1:0] sel_idx;
  logic             idx_ok;
  logic [NBITS-1:0] q_next;

  // Scan offsets from the far end so the requester closest to ptr wins.
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    cand    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[PTR_W'(cand)]) begin
        any_req = 1'b1;
        gnt     = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    sel_s   = 1'b0;
    sel_r   = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == PTR_W'(i)) begin
        sel_s   = s[i];
        sel_r   = r[i];
        sel_idx = idx[i*IDX_W +: IDX_W];
      end
    end
  end

  // s=r=1 and out-of-range indices leave the bank untouched.
  always_comb begin
    idx_ok = 1'b0;
    q_next = q;
    for (int b = 0; b < NBITS; b++) begin
      if (idx_l == IDX_W'(b)) begin
        idx_ok = 1'b1;
        if (s_l != r_l) q_next[b] = s_l;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt_l <= '0;
      s_l   <= 1'b0;
      r_l   <= 1'b0;
      idx_l <= '0;
      q     <= '0;
      ack   <= '0;
      err   <= 1'b0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_l <= gnt;
            s_l   <= sel_s;
            r_l   <= sel_r;
            idx_l <= sel_idx;
            state <= APPLY;
          end
        end
        APPLY: begin
          q     <= q_next;
          ack   <= NREQ'(1) << gnt_l;
          err   <= ~idx_ok | (s_l & r_l);
          state <= ACK;
        end
        ACK: begin
          ptr   <= (gnt_l == PTR_W'(NREQ - 1)) ? '0 : gnt_l + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign qbar = ~q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter; index width 4 so out-of-range indices can be driven.
module tb_sr_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDX_W = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       s;
  logic [NREQ-1:0]       r;
  logic [NREQ*IDX_W-1:0] idx;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic                  busy;
  logic [NBITS-1:0]      q;
  logic [NBITS-1:0]      qbar;

  int tests = 0;
  int fails = 0;

  logic [NREQ-1:0]  cap_ack;
  logic             cap_err;
  logic [NBITS-1:0] cap_q;

  sr_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .req(req), .s(s), .r(r), .idx(idx),
    .ack(ack), .err(err), .busy(busy), .q(q), .qbar(qbar)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i, input logic sv, input logic rv, input logic [IDX_W-1:0] ix);
    s[i] = sv;
    r[i] = rv;
    idx[i*IDX_W +: IDX_W] = ix;
  endtask

  // Single-requester transaction; captures outputs in the ACK cycle.
  task automatic do_op(input int i, input logic sv, input logic rv, input logic [IDX_W-1:0] ix);
    set_fields(i, sv, rv, ix);
    req = '0;
    req[i] = 1'b1;
    tick();
    tick();
    cap_ack = ack;
    cap_err = err;
    cap_q   = q;
    req = '0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; s = '0; r = '0; idx = '0;
    tick();
    tick();
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
    tests++; if (qbar !== 8'hFF) begin fails++; $display("FAIL reset_qbar: got %h expected %h", qbar, 8'hFF); end
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b expected %b", ack, 4'b0000); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_set();
    set_fields(0, 1'b1, 1'b0, 4'd3);
    req = 4'b0001;
    tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_apply: got %b expected %b", busy, 1'b1); end
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL basic_ack_apply: got %b expected %b", ack, 4'b0000); end
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL basic_q_apply: got %h expected %h", q, 8'h00); end
    tick();
    tests++; if (q !== 8'h08) begin fails++; $display("FAIL basic_q_ack: got %h expected %h", q, 8'h08); end
    tests++; if (ack !== 4'b0001) begin fails++; $display("FAIL basic_ack: got %b expected %b", ack, 4'b0001); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b expected %b", err, 1'b0); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_ack: got %b expected %b", busy, 1'b1); end
    req = '0;
    tick();
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL basic_ack_idle: got %b expected %b", ack, 4'b0000); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_idle: got %b expected %b", busy, 1'b0); end
    tests++; if (qbar !== 8'hF7) begin fails++; $display("FAIL basic_qbar: got %h expected %h", qbar, 8'hF7); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]  exp_ack [5];
    logic [NBITS-1:0] exp_q   [5];
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100;
    exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
    exp_q[0] = 8'h01; exp_q[1] = 8'h03; exp_q[2] = 8'h07; exp_q[3] = 8'h0F; exp_q[4] = 8'h0F;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_fields(i, 1'b1, 1'b0, IDX_W'(i));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      tick();
      tests++; if (ack !== exp_ack[n]) begin fails++; $display("FAIL rr_ack_%0d: got %b expected %b", n, ack, exp_ack[n]); end
      tests++; if (q !== exp_q[n]) begin fails++; $display("FAIL rr_q_%0d: got %h expected %h", n, q, exp_q[n]); end
      if (n == 4) req = '0;
      tick();
    end
    tests++; if (q !== 8'h0F) begin fails++; $display("FAIL rr_q_final: got %h expected %h", q, 8'h0F); end
  endtask

  task automatic test_clear_hold();
    for (int b = 4; b < 8; b++) do_op(3, 1'b1, 1'b0, IDX_W'(b));
    tests++; if (q !== 8'hFF) begin fails++; $display("FAIL fill_q: got %h expected %h", q, 8'hFF); end
    do_op(2, 1'b0, 1'b1, 4'd7);
    tests++; if (cap_q !== 8'h7F) begin fails++; $display("FAIL clear_q: got %h expected %h", cap_q, 8'h7F); end
    tests++; if (cap_ack !== 4'b0100) begin fails++; $display("FAIL clear_ack: got %b expected %b", cap_ack, 4'b0100); end
    tests++; if (cap_err !== 1'b0) begin fails++; $display("FAIL clear_err: got %b expected %b", cap_err, 1'b0); end
    do_op(2, 1'b0, 1'b0, 4'd0);
    tests++; if (cap_q !== 8'h7F) begin fails++; $display("FAIL hold_q: got %h expected %h", cap_q, 8'h7F); end
    tests++; if (cap_ack !== 4'b0100) begin fails++; $display("FAIL hold_ack: got %b expected %b", cap_ack, 4'b0100); end
    tests++; if (cap_err !== 1'b0) begin fails++; $display("FAIL hold_err: got %b expected %b", cap_err, 1'b0); end
  endtask

  task automatic test_errors();
    do_op(1, 1'b1, 1'b1, 4'd2);
    tests++; if (cap_q !== 8'h7F) begin fails++; $display("FAIL sr11_q: got %h expected %h", cap_q, 8'h7F); end
    tests++; if (cap_ack !== 4'b0010) begin fails++; $display("FAIL sr11_ack: got %b expected %b", cap_ack, 4'b0010); end
    tests++; if (cap_err !== 1'b1) begin fails++; $display("FAIL sr11_err: got %b expected %b", cap_err, 1'b1); end
    do_op(1, 1'b0, 1'b1, 4'd9);
    tests++; if (cap_q !== 8'h7F) begin fails++; $display("FAIL range_q: got %h expected %h", cap_q, 8'h7F); end
    tests++; if (cap_ack !== 4'b0010) begin fails++; $display("FAIL range_ack: got %b expected %b", cap_ack, 4'b0010); end
    tests++; if (cap_err !== 1'b1) begin fails++; $display("FAIL range_err: got %b expected %b", cap_err, 1'b1); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_idle: got %b expected %b", err, 1'b0); end
  endtask

  task automatic test_reset_mid_op();
    set_fields(1, 1'b1, 1'b0, 4'd6);
    set_fields(2, 1'b1, 1'b0, 4'd5);
    req = 4'b0110;
    tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b expected %b", busy, 1'b1); end
    #3 rst = 1'b1;
    #1;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL mid_q_async: got %h expected %h", q, 8'h00); end
    tests++; if (qbar !== 8'hFF) begin fails++; $display("FAIL mid_qbar_async: got %h expected %h", qbar, 8'hFF); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_async: got %b expected %b", busy, 1'b0); end
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL mid_ack_async: got %b expected %b", ack, 4'b0000); end
    tick();
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL mid_ack_held: got %b expected %b", ack, 4'b0000); end
    #3 rst = 1'b0;
    tick();
    tick();
    tests++; if (ack !== 4'b0010) begin fails++; $display("FAIL regrant_ack: got %b expected %b", ack, 4'b0010); end
    tests++; if (q !== 8'h40) begin fails++; $display("FAIL regrant_q: got %h expected %h", q, 8'h40); end
    req = 4'b0100;
    tick();
    tick();
    tick();
    tests++; if (ack !== 4'b0100) begin fails++; $display("FAIL next_ack: got %b expected %b", ack, 4'b0100); end
    tests++; if (q !== 8'h60) begin fails++; $display("FAIL next_q: got %h expected %h", q, 8'h60); end
    req = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req = '0; s = '0; r = '0; idx = '0;
    test_reset();
    test_basic_set();
    test_round_robin();
    test_clear_hold();
    test_errors();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
